nibble_serial_add_ctrl: RTL and testbench

//   Sequences one 4-bit adder slice to add WIDTH-bit operands one nibble per clock, LSB nibble first.
//   The carry is chained between cycles.

---
 rtl/addctrl_pkg.sv | 23 ++
 rtl/nibble_serial_add_ctrl_slice.sv | 27 ++
 rtl/nibble_serial_add_ctrl.sv | 118 +++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addctrl_pkg.sv
// Shared types and constants for the nibble-serial add controller.
// Used by nibble_serial_add_ctrl and its adder slice.
package addctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for n states, never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Combinational 4-bit ripple-carry adder slice.
// One instance is reused every cycle by the serial controller.
module four_bit_add_slice
  import addctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s4,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  // Explicit ripple chain through the four bit positions.
  always_comb begin
    c    = '0;
    s4   = '0;
    c[0] = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s4[i]   = a4[i] ^ b4[i] ^ c[i];
      c[i+1]  = (a4[i] & b4[i]) | (c[i] & (a4[i] ^ b4[i]));
    end
    cout = c[NIBBLE_W];
  end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds WIDTH-bit operands one nibble per clock through one 4-bit slice.
// Optional subtract (sub port, A+~B+1) with `define ADDCTRL_SUBTRACT_EN.
module nibble_serial_add_ctrl
  import addctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADDCTRL_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = clog2(NIB);
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic                sub_w;
  logic [NIBBLE_W-1:0] sl_s;
  logic                sl_c;

`ifdef ADDCTRL_SUBTRACT_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  four_bit_add_slice u_slice (
    .a4   (opa_q[NIBBLE_W-1:0]),
    .b4   (opb_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .s4   (sl_s),
    .cout (sl_c)
  );

  // Handshake flags decode from state only.
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Next-state: capture, nibble stepping, and response hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          opa_d   = a;
          opb_d   = sub_w ? ~b : b;
          carry_d = sub_w;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = {sl_s, sum_q[WIDTH-1:NIBBLE_W]};
        opa_d   = opa_q >> NIBBLE_W;
        opb_d   = opb_q >> NIBBLE_W;
        carry_d = sl_c;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cout_d  = sl_c;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All controller state in one register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl, WIDTH=16.
// Subtract cases run when ADDCTRL_SUBTRACT_EN is defined.
module tb_nibble_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
`ifdef ADDCTRL_SUBTRACT_EN
  logic         sub = 1'b0;
`endif
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a         (a),
    .b         (b),
`ifdef ADDCTRL_SUBTRACT_EN
    .sub       (sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .sum       (sum),
    .cout      (cout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs);
    a = xa;
    b = xb;
`ifdef ADDCTRL_SUBTRACT_EN
    sub = xs;
`else
    if (xs) $display("note: subtract requested without macro");
`endif
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  // Counts edges from acceptance until rsp_valid; 99 on timeout.
  task automatic wait_rsp(output int lat, output int low);
    lat = 0;
    low = 0;
    while (1) begin
      if (!req_ready) low++;
      if (rsp_valid) break;
      if (lat >= 50) begin
        lat = 99;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset: rr=%b rv=%b sum=%h c=%b want 1 0 0000 0",
               req_ready, rsp_valid, sum, cout);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add(input string nm, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input logic [W-1:0] es,
                          input logic ec);
    int lat, low;
    accept(xa, xb, 1'b0);
    wait_rsp(lat, low);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d want 4", nm, lat);
    end
    checks++;
    if (low !== 5) begin
      errors++;
      $display("FAIL %s_req_ready_low: got %0d cycles want 5", nm, low);
    end
    checks++;
    if (sum !== es || cout !== ec) begin
      errors++;
      $display("FAIL %s_result: got %h/%b want %h/%b", nm, sum, cout, es, ec);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sum !== es) begin
      errors++;
      $display("FAIL %s_release: rv=%b rr=%b sum=%h want 0 1 %h",
               nm, rsp_valid, req_ready, sum, es);
    end
  endtask

  task automatic test_backpressure();
    int lat, low;
    accept(16'h00FF, 16'h0001, 1'b0);
    wait_rsp(lat, low);
    for (int i = 0; i < 5; i++) begin
      a = 16'hAAAA;
      b = 16'h5555;
      req_valid = i[0];
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 ||
          sum !== 16'h0100 || cout !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b rr=%b sum=%h c=%b want 1 0 0100 0",
                 i, rsp_valid, req_ready, sum, cout);
      end
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || sum !== 16'h0100) begin
      errors++;
      $display("FAIL bp_release: rv=%b rr=%b sum=%h want 0 1 0100",
               rsp_valid, req_ready, sum);
    end
  endtask

  task automatic test_async_reset();
    accept(16'hAAAA, 16'h0001, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: rv=%b sum=%h c=%b rr=%b want 0 0000 0 1",
               rsp_valid, sum, cout, req_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: rv=%b rr=%b want 0 1", rsp_valid, req_ready);
    end
    test_add("after_reset", 16'h0F0F, 16'h00F1, 16'h1000, 1'b0);
  endtask

`ifdef ADDCTRL_SUBTRACT_EN
  task automatic test_subtract();
    logic [W-1:0] ea [2] = '{16'h0005, 16'h0007};
    logic [W-1:0] eb [2] = '{16'h0007, 16'h0005};
    logic [W-1:0] es [2] = '{16'hFFFE, 16'h0002};
    logic         ec [2] = '{1'b0, 1'b1};
    int lat, low;
    for (int i = 0; i < 2; i++) begin
      accept(ea[i], eb[i], 1'b1);
      sub = 1'b0;
      wait_rsp(lat, low);
      checks++;
      if (lat !== 4 || sum !== es[i] || cout !== ec[i]) begin
        errors++;
        $display("FAIL sub%0d: lat=%0d got %h/%b want 4 %h/%b",
                 i, lat, sum, cout, es[i], ec[i]);
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] pa [3] = '{16'h0001, 16'h8000, 16'h1111};
    logic [W-1:0] pb [3] = '{16'h0002, 16'h8000, 16'hEEEE};
    logic [W-1:0] es [3] = '{16'h0003, 16'h0000, 16'hFFFF};
    logic         ec [3] = '{1'b0, 1'b1, 1'b0};
    int acc [3];
    int idx = 0;
    int got = 0;
    int cyc = 0;
    rsp_ready = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (rsp_valid) begin
        checks++;
        if (sum !== es[got] || cout !== ec[got]) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h/%b want %h/%b",
                   got, sum, cout, es[got], ec[got]);
        end
        got++;
        if (got == 3) req_valid = 1'b0;
      end
      if (req_ready && idx < 3) begin
        acc[idx] = cyc;
        a = pa[idx];
        b = pb[idx];
        req_valid = 1'b1;
        idx++;
      end
      step();
      cyc++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (got !== 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d responses want 3", got);
    end
    for (int i = 1; i < 3; i++) begin
      checks++;
      if (idx < 3 || acc[i] - acc[i-1] !== 6) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d want 6", i,
                 (idx < 3) ? -1 : acc[i] - acc[i-1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add("carry_wrap", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    test_add("nibbles", 16'h1234, 16'h4321, 16'h5555, 1'b0);
    test_backpressure();
    test_async_reset();
`ifdef ADDCTRL_SUBTRACT_EN
    test_subtract();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
